// File: rtl/uart_boot_loader.sv
// UART boot loader: receives A5-framed packets on an 8N1 serial line and
// turns them into little-endian 32-bit memory word writes starting at BASE_ADDR.
module uart_boot_loader #(
   parameter int          CLK_DIV   = 54,
   parameter int          DBIT      = 8,
   parameter int          SB_TICK   = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic        mem_we,
   output logic        busy,
   output logic        done,
   output logic        frame_err
);

   localparam int             TW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0]  TICK_LAST   = TW'(CLK_DIV - 1);
   localparam int             SW          = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam logic [SW-1:0]  S_MID       = SW'(7);
   localparam logic [SW-1:0]  S_BIT_LAST  = SW'(15);
   localparam logic [SW-1:0]  S_STOP_LAST = SW'(SB_TICK - 1);
   localparam int             NW          = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [NW-1:0]  N_LAST      = NW'(DBIT - 1);
   localparam logic [7:0]     SYNC_BYTE   = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {P_SYNC, P_LEN0, P_LEN1, P_DATA} pkt_state_t;

   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic            rx_meta;
   logic            rx_sync;

   rx_state_t       rx_state;
   rx_state_t       rx_next;
   logic [SW-1:0]   s_cnt;
   logic [NW-1:0]   n_cnt;
   logic [DBIT-1:0] b_reg;
   logic            s_clr;
   logic            s_inc;
   logic            n_clr;
   logic            n_inc;
   logic            shift_en;
   logic            byte_valid;
   logic            stop_err;
   logic [7:0]      rx_byte;

   pkt_state_t      pkt_state;
   pkt_state_t      pkt_next;
   logic [7:0]      len_lo;
   logic [15:0]     len_full;
   logic [15:0]     words_left;
   logic [31:0]     addr;
   logic [23:0]     word;
   logic [1:0]      byte_idx;
   logic            start_pkt;
   logic            latch_lo;
   logic            load_len;
   logic            empty_pkt;
   logic            store_byte;
   logic            issue_write;
   logic            last_write;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    tick_cnt <= '0;
      else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                           tick_cnt <= tick_cnt + TW'(1);
   end

   assign tick = (tick_cnt == TICK_LAST);

   // The line idles high, so the synchroniser resets to 1 to avoid a false start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      if (tick) begin
         case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (s_cnt == S_MID) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (s_cnt == S_BIT_LAST && n_cnt == N_LAST) rx_next = RX_STOP;
            RX_STOP:  if (s_cnt == S_STOP_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
         endcase
      end
   end

   always_comb begin
      s_clr      = 1'b0;
      s_inc      = 1'b0;
      n_clr      = 1'b0;
      n_inc      = 1'b0;
      shift_en   = 1'b0;
      byte_valid = 1'b0;
      stop_err   = 1'b0;
      if (tick) begin
         case (rx_state)
            RX_IDLE: s_clr = !rx_sync;
            RX_START: begin
               if (s_cnt == S_MID) begin
                  s_clr = 1'b1;
                  n_clr = 1'b1;
               end else begin
                  s_inc = 1'b1;
               end
            end
            RX_DATA: begin
               if (s_cnt == S_BIT_LAST) begin
                  s_clr    = 1'b1;
                  shift_en = 1'b1;
                  n_inc    = 1'b1;
               end else begin
                  s_inc = 1'b1;
               end
            end
            RX_STOP: begin
               if (s_cnt == S_STOP_LAST) begin
                  byte_valid = rx_sync;
                  stop_err   = !rx_sync;
               end else begin
                  s_inc = 1'b1;
               end
            end
            default: s_clr = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_cnt <= '0;
         n_cnt <= '0;
         b_reg <= '0;
      end else begin
         if (s_clr)      s_cnt <= '0;
         else if (s_inc) s_cnt <= s_cnt + SW'(1);
         if (n_clr)      n_cnt <= '0;
         else if (n_inc) n_cnt <= n_cnt + NW'(1);
         if (shift_en)   b_reg <= {rx_sync, b_reg[DBIT-1:1]};
      end
   end

   assign rx_byte  = b_reg[7:0];
   assign len_full = {rx_byte, len_lo};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pkt_state <= P_SYNC;
      else        pkt_state <= pkt_next;
   end

   // A bad stop bit abandons whatever packet is in flight.
   always_comb begin
      pkt_next = pkt_state;
      if (stop_err) begin
         pkt_next = P_SYNC;
      end else if (byte_valid) begin
         case (pkt_state)
            P_SYNC: if (rx_byte == SYNC_BYTE) pkt_next = P_LEN0;
            P_LEN0: pkt_next = P_LEN1;
            P_LEN1: pkt_next = (len_full == 16'd0) ? P_SYNC : P_DATA;
            P_DATA: if (byte_idx == 2'd3 && words_left == 16'd1) pkt_next = P_SYNC;
            default: pkt_next = P_SYNC;
         endcase
      end
   end

   always_comb begin
      start_pkt   = 1'b0;
      latch_lo    = 1'b0;
      load_len    = 1'b0;
      empty_pkt   = 1'b0;
      store_byte  = 1'b0;
      issue_write = 1'b0;
      last_write  = 1'b0;
      if (byte_valid) begin
         case (pkt_state)
            P_SYNC: start_pkt = (rx_byte == SYNC_BYTE);
            P_LEN0: latch_lo  = 1'b1;
            P_LEN1: begin
               empty_pkt = (len_full == 16'd0);
               load_len  = (len_full != 16'd0);
            end
            P_DATA: begin
               store_byte  = 1'b1;
               issue_write = (byte_idx == 2'd3);
               last_write  = (byte_idx == 2'd3) && (words_left == 16'd1);
            end
            default: start_pkt = 1'b0;
         endcase
      end
   end

   // The fourth byte goes straight onto the bus, so only the low three bytes are buffered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo      <= '0;
         words_left  <= '0;
         addr        <= '0;
         word        <= '0;
         byte_idx    <= '0;
         mem_address <= '0;
         mem_data    <= '0;
         mem_we      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (start_pkt) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;
         end
         if (latch_lo) len_lo <= rx_byte;
         if (empty_pkt) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
         if (load_len) begin
            words_left <= len_full;
            addr       <= BASE_ADDR;
            byte_idx   <= 2'd0;
         end
         if (store_byte) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx != 2'd3) word[{byte_idx, 3'b000} +: 8] <= rx_byte;
         end
         if (issue_write) begin
            mem_we      <= 1'b1;
            mem_address <= addr;
            mem_data    <= {rx_byte, word};
            addr        <= addr + 32'd4;
            words_left  <= words_left - 16'd1;
         end
         if (last_write) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
         if (stop_err) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: table of packet vectors, hand-written reset and
// glitch sequences, then random packets checked against a packet-level model.
module tb_uart_boot_loader;

   localparam int          CLK_DIV  = 2;
   localparam int          BIT_CLKS = 16 * CLK_DIV;
   localparam logic [31:0] BASE     = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx = 1'b1;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        frame_err;

   uart_boot_loader #(
      .CLK_DIV(CLK_DIV), .DBIT(8), .SB_TICK(16), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we),
      .busy(busy), .done(done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        done_v;
      logic        busy_v;
      longint      lat;
   } wr_t;

   typedef struct {
      logic [15:0][7:0] bytes;
      int               n;
      int               bad_idx;
      int               exp_nw;
      logic [1:0][31:0] exp_addr;
      logic [1:0][31:0] exp_data;
      logic             exp_busy;
      logic             exp_done;
      logic             exp_ferr;
   } vec_t;

   wr_t         wr_q[$];
   logic [7:0]  pkt_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   vec_t        vecs[6];
   longint      cyc = 0;
   longint      stop_cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Every strobe is logged once per clk it is high, so a stretched pulse shows up as an extra write.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_t w;
         w.addr   = mem_address;
         w.data   = mem_data;
         w.done_v = done;
         w.busy_v = busy;
         w.lat    = cyc - stop_cyc;
         wr_q.push_back(w);
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic good_stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      stop_cyc = cyc;
      rx = good_stop;
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b1;
   endtask

   function automatic vec_t mk(input int n, input logic [127:0] raw, input int bad, input int nw,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic eb, input logic ed, input logic ef);
      vec_t v;
      logic [127:0] al;
      al = raw << (8 * (16 - n));
      for (int i = 0; i < 16; i++) v.bytes[i] = al[127 - 8*i -: 8];
      v.n = n;
      v.bad_idx = bad;
      v.exp_nw = nw;
      v.exp_addr[0] = a0;
      v.exp_data[0] = d0;
      v.exp_addr[1] = a1;
      v.exp_data[1] = d1;
      v.exp_busy = eb;
      v.exp_done = ed;
      v.exp_ferr = ef;
      return v;
   endfunction

   task automatic apply_stimulus(input vec_t v);
      for (int i = 0; i < v.n; i++) send_byte(v.bytes[i], (i != v.bad_idx));
   endtask

   // Reference model: find the sync byte, read the 16-bit count, then slice words little-endian.
   task automatic model_packet();
      int i;
      int n;
      exp_addr_q.delete();
      exp_data_q.delete();
      i = 0;
      while (i < pkt_q.size() && pkt_q[i] != 8'hA5) i++;
      n = {pkt_q[i+2], pkt_q[i+1]};
      for (int w = 0; w < n; w++) begin
         exp_addr_q.push_back(BASE + 32'(4 * w));
         exp_data_q.push_back({pkt_q[i+6+4*w], pkt_q[i+5+4*w], pkt_q[i+4+4*w], pkt_q[i+3+4*w]});
      end
   endtask

   task automatic check_writes(input string tag);
      check_output({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_addr_q.size()));
      for (int k = 0; k < exp_addr_q.size() && k < wr_q.size(); k++) begin
         check_output($sformatf("%s_addr%0d", tag, k), wr_q[k].addr, exp_addr_q[k]);
         check_output($sformatf("%s_data%0d", tag, k), wr_q[k].data, exp_data_q[k]);
      end
   endtask

   task automatic send_simple(input logic [31:0] data);
      pkt_q.delete();
      pkt_q.push_back(8'hA5);
      pkt_q.push_back(8'h01);
      pkt_q.push_back(8'h00);
      for (int i = 0; i < 4; i++) pkt_q.push_back(data[8*i +: 8]);
      model_packet();
      foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
      repeat (2 * BIT_CLKS) @(negedge clk);
   endtask

   initial begin
      int bad;
      vecs[0] = mk(11, 88'hA5_02_00_78_56_34_12_EF_BE_AD_DE, -1, 2,
                   32'h0, 32'h12345678, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      vecs[1] = mk(5, 40'h00_FF_A5_00_00, -1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      vecs[2] = mk(5, 40'hA5_01_00_11_22, 4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      vecs[3] = mk(7, 56'hA5_01_00_AA_BB_CC_DD, -1, 1,
                   32'h0, 32'hDDCCBBAA, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      vecs[4] = mk(11, 88'hA5_03_00_01_02_03_04_05_06_07_08, -1, 2,
                   32'h0, 32'h04030201, 32'h4, 32'h08070605, 1'b1, 1'b0, 1'b0);
      vecs[5] = mk(4, 32'h09_0A_0B_0C, -1, 1, 32'h8, 32'h0C0B0A09, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         rx = 1'($urandom_range(0, 1));
         if ({mem_address, mem_data, mem_we, busy, done, frame_err} != '0) bad++;
      end
      check_output("reset_outputs_zero", 32'(bad), 32'd0);
      rx = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (200) @(negedge clk);
      check_output("idle_outputs_zero", 32'(|{mem_address, mem_data, mem_we, busy, done, frame_err}), 32'd0);
      check_output("idle_no_writes", 32'(wr_q.size()), 32'd0);

      for (int v = 0; v < 6; v++) begin
         wr_q.delete();
         apply_stimulus(vecs[v]);
         repeat (2 * BIT_CLKS) @(negedge clk);
         check_output($sformatf("v%0d_nwrites", v), 32'(wr_q.size()), 32'(vecs[v].exp_nw));
         for (int k = 0; k < vecs[v].exp_nw && k < wr_q.size(); k++) begin
            check_output($sformatf("v%0d_addr%0d", v, k), wr_q[k].addr, vecs[v].exp_addr[k]);
            check_output($sformatf("v%0d_data%0d", v, k), wr_q[k].data, vecs[v].exp_data[k]);
            check_output($sformatf("v%0d_done_at_we%0d", v, k), 32'(wr_q[k].done_v),
                         32'(vecs[v].exp_done && (k == vecs[v].exp_nw - 1)));
            check_output($sformatf("v%0d_busy_at_we%0d", v, k), 32'(wr_q[k].busy_v),
                         32'(!(vecs[v].exp_done && (k == vecs[v].exp_nw - 1))));
            check_output($sformatf("v%0d_latency%0d", v, k),
                         32'(wr_q[k].lat >= 16 && wr_q[k].lat < BIT_CLKS), 32'd1);
         end
         check_output($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
         check_output($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
         check_output($sformatf("v%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
      end

      // A start pulse shorter than half a bit must be rejected and leave framing intact.
      wr_q.delete();
      @(negedge clk);
      rx = 1'b0;
      repeat (4 * CLK_DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check_output("glitch_no_writes", 32'(wr_q.size()), 32'd0);
      check_output("glitch_busy", 32'(busy), 32'd0);
      send_simple(32'hCAFEF00D);
      check_writes("glitch_then_pkt");

      wr_q.delete();
      foreach (vecs[3].bytes[i]) if (i < 5) send_byte(vecs[3].bytes[i], 1'b1);
      repeat (5) @(negedge clk);
      check_output("midword_busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check_output("midword_reset_outputs", 32'(|{mem_address, mem_data, mem_we, busy, done, frame_err}), 32'd0);
      reset = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check_output("midword_no_write", 32'(wr_q.size()), 32'd0);
      send_simple(32'h44332211);
      check_writes("after_reset_pkt");
      check_output("after_reset_done", 32'(done), 32'd1);

      for (int r = 0; r < 5; r++) begin
         int n;
         int pre;
         logic [7:0] b;
         pkt_q.delete();
         pre = $urandom_range(0, 2);
         n = $urandom_range(0, 3);
         for (int i = 0; i < pre; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            pkt_q.push_back(b);
         end
         pkt_q.push_back(8'hA5);
         pkt_q.push_back(8'(n));
         pkt_q.push_back(8'h00);
         for (int i = 0; i < 4 * n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
         model_packet();
         wr_q.delete();
         foreach (pkt_q[i]) begin
            send_byte(pkt_q[i], 1'b1);
            repeat ($urandom_range(0, 8)) @(negedge clk);
         end
         repeat (2 * BIT_CLKS) @(negedge clk);
         check_writes($sformatf("rand%0d", r));
         check_output($sformatf("rand%0d_done", r), 32'(done), 32'd1);
         check_output($sformatf("rand%0d_busy", r), 32'(busy), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
